// File: rtl/sa_pkg.sv
// Shared types for the west-edge skew feeder: read FSM states and write-mode encodings.
// No logic here; latency and backpressure are properties of the modules that import it.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic WR_MODE_ROW = 1'b0;
  localparam logic WR_MODE_RR  = 1'b1;

endpackage

// File: rtl/sa_row_fifo.sv
// Single-row synchronous FIFO with a registered read port: pop in cycle c, data/valid in c+1.
// Writes to a full FIFO and pops from an empty one are ignored; the caller owns flow control.
module sa_row_fifo #(
  parameter int W_DATA = 8,
  parameter int W_ADDR = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [W_DATA-1:0] push_dat,
  input  logic              pop,
  output logic [W_DATA-1:0] pop_dat,
  output logic              pop_vld,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 1 << W_ADDR;

  logic [W_DATA-1:0] mem [DEPTH];
  logic [W_ADDR:0]   wr_ptr;
  logic [W_ADDR:0]   rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[W_ADDR] != rd_ptr[W_ADDR]) &&
                   (wr_ptr[W_ADDR-1:0] == rd_ptr[W_ADDR-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[W_ADDR-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pop_dat <= '0;
      pop_vld <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        pop_dat <= mem[rd_ptr[W_ADDR-1:0]];
        pop_vld <= 1'b1;
      end else begin
        pop_dat <= '0;
        pop_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/west_skew_feeder.sv
// Row FIFO bank feeding the array's west edge; a start launches a diagonal burst, row r lagging r cycles.
// Read data lands 1 cycle after each scheduled pop; writes stall via o_wr_ready when any targeted row is full.
module west_skew_feeder
  import sa_pkg::*;
#(
  parameter int ROW    = 9,
  parameter int W_DATA = 8,
  parameter int W_ADDR = 4,
  parameter int W_LEN  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_mode,
  input  logic                  i_wr_valid,
  input  logic [ROW-1:0]        i_wr_row_en,
  input  logic [W_DATA-1:0]     i_data,
  output logic                  o_wr_ready,
  input  logic                  i_start,
  input  logic [W_LEN-1:0]      i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ROW*W_DATA-1:0] o_data,
  output logic [ROW-1:0]        o_data_valid,
  output logic [ROW-1:0]        o_fifo_empty,
  output logic [ROW-1:0]        o_fifo_full,
  output logic                  o_underrun
);

  localparam int TW  = W_LEN + $clog2(ROW) + 1;
  localparam int WPW = (ROW > 1) ? $clog2(ROW) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [TW-1:0]     t_q;
  logic [W_LEN-1:0]  len_q;
  logic [TW-1:0]     len_t;
  logic [TW-1:0]     last_t;
  logic [WPW-1:0]    wp_q;
  logic [ROW-1:0]    push_vec;
  logic [ROW-1:0]    sched;
  logic              wr_ready;
  logic              run;
  logic              start_burst;
  logic              wr_accept;

  assign run         = (state_q == ST_RUN);
  assign len_t       = TW'(len_q);
  assign last_t      = len_t + TW'(ROW - 2);
  assign start_burst = (state_q == ST_IDLE) && i_start && (i_len != '0);
  assign wr_accept   = i_wr_valid && wr_ready;

  // Full flags are registered, so a row popped this cycle still refuses a write.
  always_comb begin
    wr_ready = 1'b1;
    push_vec = '0;
    if (i_wr_mode == WR_MODE_RR) begin
      wr_ready       = ~o_fifo_full[wp_q];
      push_vec[wp_q] = i_wr_valid & wr_ready;
    end else begin
      wr_ready = ~|(i_wr_row_en & o_fifo_full);
      if (i_wr_valid && wr_ready) begin
        push_vec = i_wr_row_en;
      end
    end
  end

  assign o_wr_ready = wr_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wp_q <= '0;
    end else if (i_wr_mode == WR_MODE_ROW) begin
      wp_q <= '0;
    end else if (wr_accept) begin
      wp_q <= (wp_q == WPW'(ROW - 1)) ? '0 : wp_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = (i_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (t_q == last_t) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_burst) begin
        len_q <= i_len;
        t_q   <= '0;
      end else if (run) begin
        t_q <= t_q + 1'b1;
      end else begin
        t_q <= '0;
      end
    end
  end

  // Empty is sampled before any same-cycle push: there is no write-to-read bypass.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_underrun <= 1'b0;
    end else if (start_burst) begin
      o_underrun <= 1'b0;
    end else if (|(sched & o_fifo_empty)) begin
      o_underrun <= 1'b1;
    end
  end

  assign o_busy = run;
  assign o_done = (state_q == ST_DONE);

  for (genvar r = 0; r < ROW; r++) begin : g_row
    localparam logic [TW-1:0] ROW_T = TW'(r);

    assign sched[r] = run && (t_q >= ROW_T) && (t_q < ROW_T + len_t);

    sa_row_fifo #(
      .W_DATA (W_DATA),
      .W_ADDR (W_ADDR)
    ) u_fifo (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .push     (push_vec[r]),
      .push_dat (i_data),
      .pop      (sched[r]),
      .pop_dat  (o_data[W_DATA*(ROW-r)-1 -: W_DATA]),
      .pop_vld  (o_data_valid[r]),
      .empty    (o_fifo_empty[r]),
      .full     (o_fifo_full[r])
    );
  end

endmodule

// File: tb/tb_west_skew_feeder.sv
// Directed bench for west_skew_feeder with per-row queue model and per-cycle expected-output scoreboard.
module tb_west_skew_feeder;

  localparam int ROW    = 9;
  localparam int W_DATA = 8;
  localparam int W_ADDR = 4;
  localparam int W_LEN  = 8;
  localparam int DEPTH  = 1 << W_ADDR;

  logic                  i_clk;
  logic                  i_rst_n;
  logic                  i_wr_mode;
  logic                  i_wr_valid;
  logic [ROW-1:0]        i_wr_row_en;
  logic [W_DATA-1:0]     i_data;
  logic                  o_wr_ready;
  logic                  i_start;
  logic [W_LEN-1:0]      i_len;
  logic                  o_busy;
  logic                  o_done;
  logic [ROW*W_DATA-1:0] o_data;
  logic [ROW-1:0]        o_data_valid;
  logic [ROW-1:0]        o_fifo_empty;
  logic [ROW-1:0]        o_fifo_full;
  logic                  o_underrun;

  west_skew_feeder #(
    .ROW(ROW), .W_DATA(W_DATA), .W_ADDR(W_ADDR), .W_LEN(W_LEN)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_mode(i_wr_mode), .i_wr_valid(i_wr_valid),
    .i_wr_row_en(i_wr_row_en), .i_data(i_data), .o_wr_ready(o_wr_ready),
    .i_start(i_start), .i_len(i_len), .o_busy(o_busy), .o_done(o_done),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_fifo_empty(o_fifo_empty),
    .o_fifo_full(o_fifo_full), .o_underrun(o_underrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [ROW-1:0]        vld;
    logic [ROW*W_DATA-1:0] dat;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  mq [ROW][$];
  int          mwp;
  logic        exp_under;
  exp_t        exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW-1:0] m_empty();
    logic [ROW-1:0] v;
    for (int r = 0; r < ROW; r++) v[r] = (mq[r].size() == 0);
    return v;
  endfunction

  function automatic logic [ROW-1:0] m_full();
    logic [ROW-1:0] v;
    for (int r = 0; r < ROW; r++) v[r] = (mq[r].size() == DEPTH);
    return v;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_empty"}, o_fifo_empty, m_empty());
    chk({tag, "_full"}, o_fifo_full, m_full());
  endtask

  task automatic do_reset(input string tag);
    i_rst_n = 1'b0;
    #1;
    chk({tag, "_rst_data"}, o_data, '0);
    chk({tag, "_rst_vld"}, o_data_valid, '0);
    chk({tag, "_rst_busy"}, o_busy, 1'b0);
    chk({tag, "_rst_done"}, o_done, 1'b0);
    chk({tag, "_rst_under"}, o_underrun, 1'b0);
    chk({tag, "_rst_empty"}, o_fifo_empty, {ROW{1'b1}});
    chk({tag, "_rst_full"}, o_fifo_full, '0);
    for (int r = 0; r < ROW; r++) mq[r].delete();
    exp_q.delete();
    exp_under = 1'b0;
    mwp = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic wr(input logic mode, input logic [ROW-1:0] en, input logic [7:0] d);
    logic           exp_rdy;
    logic [ROW-1:0] fl;
    fl = m_full();
    if (mode) exp_rdy = !fl[mwp];
    else      exp_rdy = !(|(en & fl));
    i_wr_mode   = mode;
    i_wr_row_en = en;
    i_data      = d;
    i_wr_valid  = 1'b1;
    #1;
    chk("wr_ready", o_wr_ready, exp_rdy);
    if (exp_rdy) begin
      if (mode) begin
        mq[mwp].push_back(d);
        mwp = (mwp == ROW - 1) ? 0 : mwp + 1;
      end else begin
        for (int r = 0; r < ROW; r++) if (en[r]) mq[r].push_back(d);
      end
    end
    if (!mode) mwp = 0;
    step();
    i_wr_valid = 1'b0;
  endtask

  // Expected lanes for cycle k after the start edge reflect pops scheduled at t = k-1.
  task automatic burst(input int len, input string tag);
    int   n;
    int   bc;
    int   dc;
    exp_t e;
    n = len + ROW - 1;
    if (len != 0) begin
      exp_under = 1'b0;
      for (int k = 1; k <= n; k++) begin
        e.vld = '0;
        e.dat = '0;
        for (int r = 0; r < ROW; r++) begin
          if ((k - 1 >= r) && (k - 1 < r + len)) begin
            if (mq[r].size() > 0) begin
              e.vld[r] = 1'b1;
              e.dat[W_DATA*(ROW-r)-1 -: W_DATA] = mq[r].pop_front();
            end else begin
              exp_under = 1'b1;
            end
          end
        end
        exp_q.push_back(e);
      end
    end
    i_start = 1'b1;
    i_len   = W_LEN'(len);
    step();
    i_start = 1'b0;
    i_len   = W_LEN'($urandom);
    if (len == 0) begin
      chk({tag, "_z_done"}, o_done, 1'b1);
      chk({tag, "_z_busy"}, o_busy, 1'b0);
      chk({tag, "_z_vld"}, o_data_valid, '0);
      step();
      chk({tag, "_z_done_end"}, o_done, 1'b0);
      chk({tag, "_z_vld_end"}, o_data_valid, '0);
      return;
    end
    chk({tag, "_first_busy"}, o_busy, 1'b1);
    chk({tag, "_first_vld"}, o_data_valid, '0);
    chk({tag, "_under_clr"}, o_underrun, 1'b0);
    bc = 1;
    dc = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      e = exp_q.pop_front();
      chk($sformatf("%s_vld_c%0d", tag, k), o_data_valid, e.vld);
      chk($sformatf("%s_dat_c%0d", tag, k), o_data, e.dat);
      if (o_busy) bc++;
      if (o_done) dc++;
    end
    step();
    if (o_done) dc++;
    chk({tag, "_tail_vld"}, o_data_valid, '0);
    chk({tag, "_busy_cycles"}, bc, n);
    chk({tag, "_done_pulses"}, dc, 1);
    chk({tag, "_underrun"}, o_underrun, exp_under);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n     = 1'b1;
    i_wr_mode   = 1'b0;
    i_wr_valid  = 1'b0;
    i_wr_row_en = '0;
    i_data      = '0;
    i_start     = 1'b0;
    i_len       = '0;
    mwp         = 0;
    exp_under   = 1'b0;
    #2;
    do_reset("init");

    // Scenario 1: broadcast three words, burst of 3.
    wr(1'b0, {ROW{1'b1}}, 8'h11);
    wr(1'b0, {ROW{1'b1}}, 8'h22);
    wr(1'b0, {ROW{1'b1}}, 8'h33);
    check_flags("s1_pre");
    burst(3, "s1");
    check_flags("s1_post");

    // Scenario 2: round-robin fill, tenth write wraps to row 0.
    for (int v = 0; v < ROW; v++) wr(1'b1, '0, 8'(v));
    wr(1'b1, '0, 8'h99);
    check_flags("s2_pre");
    burst(1, "s2");
    check_flags("s2_post");

    // Scenario 3: fill row 0, overflow write dropped, other row still writable.
    while (mq[0].size() < DEPTH) wr(1'b0, 9'h001, 8'($urandom));
    check_flags("s3_full");
    chk("s3_full0", o_fifo_full[0], 1'b1);
    wr(1'b0, 9'h001, 8'hEE);
    wr(1'b0, 9'h002, 8'h5A);
    wr(1'b0, 9'h000, 8'h77);
    check_flags("s3_post");

    // Scenario 4: row 8 one word short produces underrun; next start clears it.
    do_reset("s4");
    wr(1'b0, 9'h1FF, 8'hA1);
    wr(1'b0, 9'h0FF, 8'hB2);
    burst(2, "s4");
    burst(1, "s4b");

    // Scenario 5: zero-length start leaves contents intact.
    wr(1'b0, {ROW{1'b1}}, 8'hC3);
    check_flags("s5_pre");
    burst(0, "s5");
    check_flags("s5_post");
    burst(1, "s5b");

    // Scenario 6: reset in the middle of a burst, then a clean rerun.
    wr(1'b0, {ROW{1'b1}}, 8'h44);
    wr(1'b0, {ROW{1'b1}}, 8'h55);
    i_start = 1'b1;
    i_len   = 8'd3;
    step();
    i_start = 1'b0;
    repeat (4) step();
    chk("s6_busy_mid", o_busy, 1'b1);
    #2;
    do_reset("s6");
    wr(1'b0, {ROW{1'b1}}, 8'h11);
    wr(1'b0, {ROW{1'b1}}, 8'h22);
    wr(1'b0, {ROW{1'b1}}, 8'h33);
    burst(3, "s6_rerun");
    check_flags("s6_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
